// File: rtl/fwht_frame_engine.sv
// Frame-based radix-2 Walsh-Hadamard engine: load SAMPLES samples, transform in place, stream out.
// Latency: first out_valid STAGES*SAMPLES/2+1 cycles after the cycle of the last input accept.
// Backpressure: out_ready stalls DRAIN with out_data held; in_ready is low outside LOAD (no frame overlap).
//
// Optional feature macro: FWHT_SCALE_EN
//   defined   -> every butterfly output is arithmetically shifted right by one (floor), giving X/SAMPLES
//   undefined -> full-growth unscaled results
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready     sample handshake, in_data is a WIDTH-bit signed sample, frame order n=0..SAMPLES-1
//   out_valid/out_ready   result handshake, out_data is X[k] (OUT_W bits signed), natural order
//   out_last              marks k=SAMPLES-1
//   busy                  high while computing or draining
module fwht_frame_engine #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WIDTH+$clog2(SAMPLES)-1:0]     out_data,
  output logic                                 out_last,
  output logic                                 busy
);

  localparam int STAGES = $clog2(SAMPLES);
  localparam int OUT_W  = WIDTH + STAGES;
  localparam int AW     = STAGES;

  localparam logic [AW-1:0] ONE_A      = AW'(1);
  localparam logic [AW-1:0] LAST_IDX   = AW'(SAMPLES - 1);
  localparam logic [AW-1:0] HALF_LAST  = AW'(SAMPLES / 2 - 1);
  localparam logic [AW-1:0] STAGE_LAST = AW'(STAGES - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  state_e state_q, state_d;
  // cnt_q is the sample index in LOAD, the butterfly index in COMPUTE and k in DRAIN
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] stage_q, stage_d;

  logic signed [OUT_W-1:0] mem_q [SAMPLES];

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = v[AW-1-i];
    end
    return r;
  endfunction

  // Butterfly addressing: insert a zero at bit position 'stage' of the butterfly index
  // to get the upper leg i; the lower leg j has that bit set.
  logic [AW-1:0] span;
  logic [AW-1:0] idx_i;
  logic [AW-1:0] idx_j;
  logic signed [OUT_W-1:0] op_a, op_b, bf_sum, bf_dif, wr_i, wr_j;
  logic signed [OUT_W-1:0] in_sext;
  logic load_wr;

  always_comb begin
    span  = ONE_A << stage_q;
    idx_i = ((cnt_q >> stage_q) << (stage_q + ONE_A)) | (cnt_q & (span - ONE_A));
    idx_j = idx_i | span;
    op_a  = mem_q[idx_i];
    op_b  = mem_q[idx_j];
    // OUT_W bits hold the full growth of STAGES passes, so these never wrap
    bf_sum = op_a + op_b;
    bf_dif = op_a - op_b;
`ifdef FWHT_SCALE_EN
    wr_i = bf_sum >>> 1;
    wr_j = bf_dif >>> 1;
`else
    wr_i = bf_sum;
    wr_j = bf_dif;
`endif
  end

  assign in_sext = {{STAGES{in_data[WIDTH-1]}}, in_data};

  // Outputs are decoded from state; in_ready is also gated by rst_n so it is low while reset is held
  assign in_ready  = rst_n && (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = out_valid && (cnt_q == LAST_IDX);
  assign out_data  = out_valid ? mem_q[bitrev(cnt_q)] : '0;
  assign busy      = (state_q != LOAD);
  assign load_wr   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    unique case (state_q)
      LOAD: begin
        if (load_wr) begin
          cnt_d = cnt_q + ONE_A;  // wraps to 0 after the last sample
          if (cnt_q == LAST_IDX) begin
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (stage_q == STAGE_LAST) begin
            stage_d = '0;
            state_d = DRAIN;
          end else begin
            stage_d = stage_q + ONE_A;
          end
        end else begin
          cnt_d = cnt_q + ONE_A;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          cnt_d = cnt_q + ONE_A;
          if (cnt_q == LAST_IDX) begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
        stage_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end

  // Sample buffer needs no reset: every entry is written during LOAD before it is read.
  // Samples land in bit-reversed slots so the in-place passes read out in natural order.
  always_ff @(posedge clk) begin
    if (load_wr) begin
      mem_q[bitrev(cnt_q)] <= in_sext;
    end else if (state_q == COMPUTE) begin
      mem_q[idx_i] <= wr_i;
      mem_q[idx_j] <= wr_j;
    end
  end

endmodule

// File: tb/tb_fwht_frame_engine.sv
// Self-checking bench for fwht_frame_engine (SAMPLES=8, WIDTH=3, OUT_W=6).
// Expected beats are computed from each driven frame and queued; drained beats are popped and compared.
// Covers reset, several data patterns, latency, backpressure, mid-operation reset and input gaps.
module tb_fwht_frame_engine;

  localparam int S  = 8;
  localparam int W  = 3;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;

  fwht_frame_engine #(.SAMPLES(S), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] dat;
    logic          last;
  } exp_t;

  exp_t              exp_q[$];
  logic signed [W-1:0] frame [S];
  int errors = 0;
  int checks = 0;

  // Reference transform on natural-order data: spans S/2 down to 1, upper leg gets a+b.
  task automatic push_model();
    int v [S];
    int a, b;
    exp_t e;
    for (int n = 0; n < S; n++) v[n] = int'(frame[n]);
    for (int h = S / 2; h >= 1; h = h / 2) begin
      for (int i = 0; i < S; i++) begin
        if ((i & h) == 0) begin
          a = v[i];
          b = v[i + h];
`ifdef FWHT_SCALE_EN
          v[i]     = (a + b) >>> 1;
          v[i + h] = (a - b) >>> 1;
`else
          v[i]     = a + b;
          v[i + h] = a - b;
`endif
        end
      end
    end
    for (int k = 0; k < S; k++) begin
      e.dat  = v[k][OW-1:0];
      e.last = (k == S - 1);
      exp_q.push_back(e);
    end
  endtask

  // Drives one frame with 'gap' idle cycles before each sample; returns at the
  // falling edge one cycle after the last accept with in_valid = hold_after.
  task automatic send_frame(input int gap, input bit hold_after);
    @(negedge clk);
    for (int n = 0; n < S; n++) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame[n];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready n=%0d: got %b want 1", n, in_ready);
      end
      @(negedge clk);
    end
    in_valid = hold_after;
    push_model();
  endtask

  // Collects nbeats accepted beats, checking them against the queue and checking
  // that a stalled beat stays put.
  task automatic receive_frame(input bit bp, input int nbeats);
    int            got = 0;
    int            cyc = 0;
    bit            held = 1'b0;
    logic [OW-1:0] held_dat = '0;
    bit            rdy;
    exp_t          e;
    while (got < nbeats && cyc < 500) begin
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_dat) begin
          errors++;
          $display("FAIL hold: got valid=%b data=%0h want valid=1 data=%0h", out_valid, out_data, held_dat);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL drain_in_ready: got %b want 0", in_ready);
        end
        if (rdy) begin
          held = 1'b0;
          got++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat: got data=%0h with nothing expected", out_data);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (out_data !== e.dat) begin
              errors++;
              $display("FAIL data beat=%0d: got %0d want %0d", got - 1, $signed(out_data), $signed(e.dat));
            end
            checks++;
            if (out_last !== e.last) begin
              errors++;
              $display("FAIL last beat=%0d: got %b want %b", got - 1, out_last, e.last);
            end
          end
        end else begin
          held     = 1'b1;
          held_dat = out_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (got < nbeats) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats want %0d", got, nbeats);
    end
    if (nbeats == S) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL back_to_load: got valid=%b in_ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
      end
    end
  endtask

  task automatic set_impulse();
    for (int n = 0; n < S; n++) frame[n] = (n == 0) ? 3'sd1 : 3'sd0;
  endtask

  task automatic set_random();
    for (int n = 0; n < S; n++) frame[n] = 3'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b dat=%0h busy=%b want all 0",
               in_ready, out_valid, out_last, out_data, busy);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_ramp();
    for (int n = 0; n < S; n++) frame[n] = 3'(n);
    send_frame(0, 1'b0);
    receive_frame(1'b0, S);
  endtask

  task automatic test_impulse_latency();
    int idx = 1;
    set_impulse();
    send_frame(0, 1'b0);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL compute_flags: got busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    while (out_valid !== 1'b1 && idx < 100) begin
      @(negedge clk);
      idx++;
    end
    checks++;
    if (idx != 13) begin
      errors++;
      $display("FAIL latency: got %0d cycles want 13", idx);
    end
    receive_frame(1'b0, S);
  endtask

  task automatic test_all_min();
`ifdef FWHT_SCALE_EN
    for (int n = 0; n < S; n++) frame[n] = 3'sd3;
`else
    for (int n = 0; n < S; n++) frame[n] = -3'sd4;
`endif
    send_frame(0, 1'b0);
    receive_frame(1'b0, S);
  endtask

  task automatic test_backpressure();
    for (int f = 0; f < 3; f++) begin
      set_random();
      send_frame(0, 1'b0);
      receive_frame(1'b1, S);
    end
  endtask

  task automatic test_reset_mid();
    // reset during COMPUTE
    set_random();
    send_frame(0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_compute: got valid=%b busy=%b want 0 0", out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    set_impulse();
    send_frame(0, 1'b0);
    receive_frame(1'b0, S);
    // reset during DRAIN
    set_random();
    send_frame(0, 1'b0);
    receive_frame(1'b0, 3);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_drain: got valid=%b last=%b in_ready=%b want 0 0 0", out_valid, out_last, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    set_impulse();
    send_frame(0, 1'b0);
    receive_frame(1'b0, S);
  endtask

  task automatic test_gaps();
    set_impulse();
    send_frame(2, 1'b1);
    in_data = 3'sd3;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL compute_no_accept c=%0d: got in_ready=%b want 0", c, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    receive_frame(1'b0, S);
    // follow-up frame proves the held in_valid left no trace
    for (int n = 0; n < S; n++) frame[n] = 3'(S - 1 - n);
    send_frame(0, 1'b0);
    receive_frame(1'b0, S);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_ramp();
    test_impulse_latency();
    test_all_min();
    test_backpressure();
    test_reset_mid();
    test_gaps();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d beats still expected want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
